// File: rtl/btn_pkg.sv
// Shared types for the push-button front end: edge-mode encodings, the
// per-channel press/hold/repeat state and a small constant helper.
package btn_pkg;

  typedef enum logic [1:0] {
    EDGE_PRESS   = 2'd0,
    EDGE_RELEASE = 2'd1,
    EDGE_BOTH    = 2'd2
  } edge_mode_e;

  typedef enum logic [1:0] {
    REL,
    HOLD,
    RPT
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stable-count debounce, edge pulse
// generation and a hold/auto-repeat FSM driving a single-cycle strobe.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = 0,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic CLK_FPGA,
  input  logic RST_N,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES)) + 1;

  localparam logic IDLE_PIN         = (ACTIVE_LOW != 0);
  localparam logic PULSE_ON_PRESS   = (EDGE_MODE != int'(EDGE_RELEASE));
  localparam logic PULSE_ON_RELEASE = (EDGE_MODE != int'(EDGE_PRESS));

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [DW-1:0] db_cnt, db_cnt_next;
  logic          db_done, rise, fall;
  btn_state_e    state, state_next;
  logic [HW-1:0] hold_cnt, hold_cnt_next;
  logic          rpt_fire, pulse_next;

  // Preset to the released pin level so leaving reset never looks like a press.
  always_ff @(posedge CLK_FPGA or negedge RST_N) begin
    if (!RST_N) sync_q <= {2{IDLE_PIN}};
    else        sync_q <= {sync_q[0], btn};
  end

  assign s = sync_q[1] ^ IDLE_PIN;

  always_comb begin
    db_done     = (s != level) && (db_cnt == DB_LAST);
    rise        = db_done & ~level;
    fall        = db_done & level;
    db_cnt_next = ((s == level) || db_done) ? '0 : db_cnt + DW'(1);
  end

  // A release on the edge a repeat is due takes priority and suppresses it.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    rpt_fire      = 1'b0;
    case (state)
      REL: begin
        if (rise) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        if (fall) begin
          state_next    = REL;
          hold_cnt_next = '0;
        end else if (HOLD_CYCLES != 0) begin
          if (hold_cnt == HOLD_LAST) begin
            state_next    = RPT;
            hold_cnt_next = '0;
            rpt_fire      = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt + HW'(1);
          end
        end
      end
      RPT: begin
        if (fall) begin
          state_next    = REL;
          hold_cnt_next = '0;
        end else if (hold_cnt == RPT_LAST) begin
          hold_cnt_next = '0;
          rpt_fire      = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_next    = REL;
        hold_cnt_next = '0;
      end
    endcase
    pulse_next = ((rise | rpt_fire) & PULSE_ON_PRESS) | (fall & PULSE_ON_RELEASE);
  end

  always_ff @(posedge CLK_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      level    <= 1'b0;
      pulse    <= 1'b0;
      db_cnt   <= '0;
      state    <= REL;
      hold_cnt <= '0;
    end else begin
      level    <= level ^ db_done;
      pulse    <= pulse_next;
      db_cnt   <= db_cnt_next;
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

endmodule

// File: rtl/debounce_pulse_array.sv
// N-channel button front end: one independent debounce_channel per pin,
// the top level only slices the buses.
module debounce_pulse_array #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = 0,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic            CLK_FPGA,
  input  logic            RST_N,
  input  logic [N_CH-1:0] Btn,
  output logic [N_CH-1:0] Level,
  output logic [N_CH-1:0] Pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .EDGE_MODE      (EDGE_MODE),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .CLK_FPGA(CLK_FPGA),
      .RST_N   (RST_N),
      .btn     (Btn[i]),
      .level   (Level[i]),
      .pulse   (Pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_pulse_array.sv
// Bench for debounce_pulse_array: two instances (press-only with auto-repeat,
// both-edges without) against a timestamp-based model, plus literal timing checks.
module tb_debounce_pulse_array;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int R  = 10;
  localparam logic AL_BIT = 1'b1;

  logic          CLK_FPGA = 1'b0;
  logic          RST_N    = 1'b0;
  logic [N-1:0]  Btn      = '1;
  logic [N-1:0]  dut_level [2];
  logic [N-1:0]  dut_pulse [2];

  always #5 CLK_FPGA = ~CLK_FPGA;

  debounce_pulse_array #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .EDGE_MODE(0),
    .HOLD_CYCLES(50), .REPEAT_CYCLES(R)
  ) u_dut_press (
    .CLK_FPGA(CLK_FPGA), .RST_N(RST_N), .Btn(Btn),
    .Level(dut_level[0]), .Pulse(dut_pulse[0])
  );

  debounce_pulse_array #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .EDGE_MODE(2),
    .HOLD_CYCLES(0), .REPEAT_CYCLES(R)
  ) u_dut_both (
    .CLK_FPGA(CLK_FPGA), .RST_N(RST_N), .Btn(Btn),
    .Level(dut_level[1]), .Pulse(dut_pulse[1])
  );

  function automatic int mode_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int hold_of(input int d);
    return (d == 0) ? 50 : 0;
  endfunction

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Model: pin value seen at edge n is the one sampled at edge n-2; the level
  // flips once the normalised value has differed from it for D straight edges.
  logic [N-1:0] samp [int];
  bit           last_sp [N];
  int           since   [N];
  bit           m_lvl   [2][N];
  int           t_press [2][N];
  bit [N-1:0]   exp_level [2];
  bit [N-1:0]   exp_pulse [2];
  bit           sp, tog, p;
  int           dt;

  always @(posedge CLK_FPGA) begin
    n = n + 1;
    if (!RST_N) begin
      samp[n] = {N{AL_BIT}};
      for (int c = 0; c < N; c++) begin
        last_sp[c] = 1'b0;
        since[c]   = n;
        for (int d = 0; d < 2; d++) m_lvl[d][c] = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        exp_level[d] = '0;
        exp_pulse[d] = '0;
      end
    end else begin
      samp[n] = Btn;
      for (int c = 0; c < N; c++) begin
        sp = samp[n-2][c] ^ AL_BIT;
        if (sp != last_sp[c]) begin
          last_sp[c] = sp;
          since[c]   = n;
        end
        for (int d = 0; d < 2; d++) begin
          tog = (sp != m_lvl[d][c]) && ((n - since[c] + 1) == D);
          p   = 1'b0;
          if (tog && !m_lvl[d][c]) begin
            m_lvl[d][c]   = 1'b1;
            t_press[d][c] = n;
            p = (mode_of(d) != 1);
          end else if (tog) begin
            m_lvl[d][c] = 1'b0;
            p = (mode_of(d) != 0);
          end else if (m_lvl[d][c] && hold_of(d) != 0 && mode_of(d) != 1) begin
            dt = n - t_press[d][c];
            p  = (dt >= hold_of(d)) && (((dt - hold_of(d)) % R) == 0);
          end
          exp_level[d][c] = m_lvl[d][c];
          exp_pulse[d][c] = p;
        end
      end
    end
  end

  typedef struct { int d; int c; int e; } pev_t;
  pev_t plog [$];

  always @(negedge CLK_FPGA) begin
    if (n > 0) begin
      for (int d = 0; d < 2; d++) begin
        total++;
        if (dut_level[d] !== exp_level[d]) begin
          bad++;
          $display("FAIL cyc_level dut%0d edge %0d: got %b want %b", d, n, dut_level[d], exp_level[d]);
        end
        total++;
        if (dut_pulse[d] !== exp_pulse[d]) begin
          bad++;
          $display("FAIL cyc_pulse dut%0d edge %0d: got %b want %b", d, n, dut_pulse[d], exp_pulse[d]);
        end
        for (int c = 0; c < N; c++)
          if (dut_pulse[d][c] === 1'b1) plog.push_back('{d: d, c: c, e: n});
      end
    end
  end

  function automatic int count_p(input int d, input int c, input int lo, input int hi);
    int k = 0;
    foreach (plog[i])
      if (plog[i].d == d && plog[i].c == c && plog[i].e >= lo && plog[i].e <= hi) k++;
    return k;
  endfunction

  function automatic int nth_p(input int d, input int c, input int lo, input int hi, input int k);
    int j = 0;
    foreach (plog[i])
      if (plog[i].d == d && plog[i].c == c && plog[i].e >= lo && plog[i].e <= hi) begin
        if (j == k) return plog[i].e;
        j++;
      end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge CLK_FPGA);
  endtask

  int e, last, r, t;
  int offs [6] = '{0, 50, 60, 70, 80, 90};
  int hl [N];

  initial begin
    // Reset with all pins released, then a quiet interval.
    RST_N = 1'b0;
    Btn   = '1;
    tick(3);
    check("rst_level_a", int'(dut_level[0]), 0);
    check("rst_pulse_a", int'(dut_pulse[0]), 0);
    RST_N = 1'b1;
    e = n + 1;
    tick(100);
    check("quiet_a", count_p(0, 0, e, n) + count_p(0, 1, e, n) + count_p(0, 2, e, n) + count_p(0, 3, e, n), 0);
    check("quiet_b", count_p(1, 0, e, n) + count_p(1, 1, e, n) + count_p(1, 2, e, n) + count_p(1, 3, e, n), 0);

    // Clean press and release on ch0.
    Btn[0] = 1'b0;
    e = n + 1;
    tick(30);
    check("press_cnt", count_p(0, 0, e, n), 1);
    check("press_edge", nth_p(0, 0, e, n, 0), e + 17);
    check("press_level", int'(dut_level[0][0]), 1);
    Btn[0] = 1'b1;
    e = n + 1;
    tick(30);
    check("rel_nopulse", count_p(0, 0, e, n), 0);
    check("rel_level", int'(dut_level[0][0]), 0);
    check("rel_both_edge", nth_p(1, 0, e, n, 0), e + 17);

    // Bounce on ch1: 13 toggles 5 cycles apart, ending pressed.
    e = n + 1;
    last = e;
    for (int k = 0; k < 13; k++) begin
      Btn[1] = ~Btn[1];
      last = n + 1;
      tick(5);
    end
    tick(35);
    check("bounce_cnt", count_p(0, 1, e, n), 1);
    check("bounce_edge", nth_p(0, 1, e, n, 0), last + 17);
    Btn[1] = 1'b1;
    tick(30);

    // Both-edges mode on ch2: press held 40 cycles.
    Btn[2] = 1'b0;
    e = n + 1;
    tick(40);
    Btn[2] = 1'b1;
    tick(40);
    check("both_cnt", count_p(1, 2, e, n), 2);
    check("both_first", nth_p(1, 2, e, n, 0), e + 17);
    check("both_gap", nth_p(1, 2, e, n, 1) - nth_p(1, 2, e, n, 0), 40);

    // Auto-repeat on ch3: release lands on the edge a repeat is due.
    Btn[3] = 1'b0;
    e = n + 1;
    tick(100);
    Btn[3] = 1'b1;
    tick(60);
    t = e + 17;
    check("rpt_cnt", count_p(0, 3, e, n), 6);
    for (int k = 0; k < 6; k++) check("rpt_edge", nth_p(0, 3, e, n, k), t + offs[k]);
    check("rpt_both_cnt", count_p(1, 3, e, n), 2);

    // Simultaneous press on ch0 and ch3.
    Btn[0] = 1'b0;
    Btn[3] = 1'b0;
    e = n + 1;
    tick(25);
    check("indep_ch0", nth_p(0, 0, e, n, 0), e + 17);
    check("indep_ch3", nth_p(0, 3, e, n, 0), e + 17);
    Btn = '1;
    tick(30);

    // Async reset while ch0 is repeating; held button needs a full debounce after.
    Btn[0] = 1'b0;
    e = n + 1;
    tick(75);
    check("rpt_before_rst", count_p(0, 0, e, n), 2);
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_level_a", int'(dut_level[0]), 0);
    check("rst_mid_pulse_a", int'(dut_pulse[0]), 0);
    check("rst_mid_level_b", int'(dut_level[1]), 0);
    check("rst_mid_pulse_b", int'(dut_pulse[1]), 0);
    tick(3);
    RST_N = 1'b1;
    r = n + 1;
    tick(40);
    check("post_rst_cnt", count_p(0, 0, r, n), 1);
    check("post_rst_edge", nth_p(0, 0, r, n, 0), r + 17);
    Btn = '1;
    tick(30);

    // Random presses, holds and bounces, checked cycle by cycle against the model.
    for (int c = 0; c < N; c++) hl[c] = $urandom_range(1, 40);
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (i == 1500) begin
        #2 RST_N = 1'b0;
        tick(3);
        RST_N = 1'b1;
      end
      for (int c = 0; c < N; c++) begin
        if (hl[c] == 0) begin
          Btn[c] = ~Btn[c];
          hl[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(15, 130);
        end else begin
          hl[c] = hl[c] - 1;
        end
      end
    end
    Btn = '1;
    tick(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_array.md
# debounce_pulse_array

Parametrised multi-channel button front end: synchronises N raw push-button inputs and debounces each with a stable-count filter. Converts each debounced level into single-cycle pulses on press, release or both, with optional hold-to-auto-repeat. Sits between the board pins and the control FSMs, replacing per-button level-to-pulse logic with one configurable block.

## Interface
- `N_CH`, 4: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required to accept a level change (≥1).
- `ACTIVE_LOW`, 1: 1 = pin low means pressed; 0 = pin high means pressed.
- `EDGE_MODE`, 0: 0 = pulse on press, 1 = pulse on release, 2 = pulse on both.
- `HOLD_CYCLES`, 0: cycles from press pulse to first auto-repeat pulse; 0 disables auto-repeat.
- `REPEAT_CYCLES`, 8: cycles between subsequent auto-repeat pulses (≥1).

Ports:
- `CLK_FPGA` in 1: single system clock, all logic on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `Btn` in N_CH: raw, asynchronous button pins.
- `Level` out N_CH: debounced state per channel, 1 = pressed, polarity-normalised.
- `Pulse` out N_CH: one-cycle event strobe per channel.

## Operation
- Per channel: 2-flop synchroniser, then polarity normalisation (invert if ACTIVE_LOW), giving `s`.
- Debounce counter: cleared whenever `s == Level`. Increments while `s != Level`. When it would reach DEBOUNCE_CYCLES, `Level` toggles and the counter clears. Any bounce back resets the count, so glitches shorter than DEBOUNCE_CYCLES never reach `Level`.
- Edge pulse: `Pulse` asserts on the same edge `Level` toggles if the toggle matches EDGE_MODE (0→1 for press, 1→0 for release, either for both).
- Per-channel FSM, states REL, HOLD, RPT:
  - REL→HOLD on Level 0→1.
  - HOLD→RPT when the hold counter reaches HOLD_CYCLES. A pulse is emitted only if HOLD_CYCLES≠0 and EDGE_MODE≠1.
  - RPT: emits a pulse every REPEAT_CYCLES cycles.
  - Any state→REL on Level 1→0. The hold counter clears.
  - With HOLD_CYCLES=0, HOLD is terminal until release.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Counter widths: `$clog2` of the respective maximum plus 1. No wrap: each counter clears on its terminal compare.

## Timing
- Reset (async, RST_N low) sets:
  - `Level` = 0, `Pulse` = 0, FSM = REL.
  - Synchroniser flops preset to the released pin value, so no spurious press on reset exit.
  - All counters = 0.
- Reset mid-press aborts the pulse train immediately. After release of reset, a still-held button needs a full debounce to be seen again.
- Latency: Btn change first sampled at edge k → `Level` and `Pulse` update at edge k+DEBOUNCE_CYCLES+1, if Btn is stable throughout.
- Auto-repeat: first repeat pulse exactly HOLD_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles.
- `Pulse` is always exactly one cycle wide. `Pulse` and `Level` are registered outputs.
- Release on the same edge a repeat pulse is due: release wins, with no repeat pulse. A release pulse is still emitted if EDGE_MODE≠0.

## Structure
- Shared package `btn_pkg`:
  - EDGE_MODE encodings (EDGE_PRESS, EDGE_RELEASE, EDGE_BOTH).
  - FSM state typedef (REL, HOLD, RPT).
- Sub-module `debounce_channel`: synchroniser, debounce counter, FSM, hold/repeat counter for one channel. Instantiated N_CH times in a generate loop. The top level only slices buses.

## Test plan
- Reset: RST_N low with Btn=all-ones (ACTIVE_LOW=1) → Level=0, Pulse=0. After release, no pulse for 100 cycles.
- Clean press, DEBOUNCE_CYCLES=16, EDGE_MODE=0:
  - Ch0 low at edge 0 → Level[0]=1 and Pulse[0]=1 at edge 17 only.
  - Release → Level[0]=0, no pulse.
- Bounce: ch1 toggles every 5 cycles for 60 cycles, then stable pressed → exactly one pulse, 17 edges after the last toggle.
- Both-edges, EDGE_MODE=2: press held 40 cycles, then release → two pulses, 40 cycles apart.
- Auto-repeat, HOLD_CYCLES=50, REPEAT_CYCLES=10, hold 100 cycles → pulses at t, t+50, t+60, t+70, t+80, t+90. None after release.
- Independence and async reset:
  - Ch0 and ch3 pressed simultaneously → coincident pulses.
  - RST_N low in RPT → Pulse=0 and Level=0 immediately.
